rsp_encode: RTL
===============

// Module: rsp_encode
// PURPOSE
//  Builds response frames for the host and writes them byte-wise into the TX FIFO.
//  It is the transmit-side counterpart of the command decoder. Protocol engines (I2C, I3C, SPI, FPR)
//  present a request of page/status/length, then stream the payload bytes.
//  Frame format: header {page[3:0],status[3:0]}, length byte, payload bytes, optional XOR checksum.
// PARAMETERS
//  MAX_LEN      64    largest accepted payload length in bytes (1..255)
//  TIMEOUT_CYC  1024  consecutive PLD cycles with pld_valid low before the frame is aborted
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  rsp_req     in   1  request strobe; sampled only in IDLE
//  rsp_page    in   4  interface page: 1=I2C, 3/4=I3C, 5=SPI, 7=FPR
//  rsp_status  in   4  status nibble placed in the header
//  rsp_len     in   8  payload byte count (0 allowed)
//  rsp_busy    out  1  frame in progress; new requests are ignored while high
//  pld_data    in   8  payload byte
//  pld_valid   in   1  pld_data is valid
//  pld_ready   out  1  encoder accepts pld_data this cycle
//  tx_full     in   1  TX FIFO full
//  tx_wr       out  1  TX FIFO write strobe, one cycle per byte
//  tx_data     out  8  TX FIFO write data
//  rsp_done    out  1  one-cycle pulse after the final byte of the frame is written
//  rsp_err     out  1  one-cycle pulse when a request is rejected or a frame is aborted
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0: rsp_busy, pld_ready, tx_wr, tx_data, rsp_done, rsp_err.
//    Checksum, byte counter and timeout counter are cleared. Any partial frame is abandoned.
//  - All outputs are registered. At most one tx_wr per cycle. tx_wr is never asserted in a cycle where tx_full=1.
//  - States: IDLE, HDR, LEN, PLD, CHK, DONE.
//  - IDLE: when rsp_req=1, latch page, status and len.
//    - If page is not in {1,3,4,5,7}, or len>MAX_LEN: pulse rsp_err next cycle, stay IDLE, write nothing.
//    - Otherwise go to HDR and set rsp_busy=1 next cycle.
//  - HDR: when !tx_full, write {page,status}, seed chk=header, go to LEN. If tx_full, hold.
//  - LEN: when !tx_full, write len and update chk^=len.
//    - len=0: go to CHK (or DONE when checksum is compiled out).
//    - Otherwise go to PLD.
//  - PLD:
//    - pld_ready = !tx_full (combinational from state, registered select).
//    - On pld_valid&&pld_ready: write pld_data, update chk^=pld_data, decrement count.
//    - When count reaches 0: go to CHK or DONE.
//    - The timeout counter increments on each PLD cycle with pld_valid=0 and clears on a transfer.
//      At TIMEOUT_CYC: pulse rsp_err, go to IDLE, clear rsp_busy. The frame is truncated and no checksum is written.
//  - CHK: when !tx_full, write chk and go to DONE.
//  - DONE: pulse rsp_done, clear rsp_busy, go to IDLE. The next request is accepted no earlier than the following cycle.
//  - Minimum latency: rsp_req at cycle N -> header write at N+2 -> last byte at N+3+len(+1 with checksum).
//  - tx_full mid-frame: the byte in flight is held and not duplicated or lost. The payload is stalled through pld_ready.
//  - rsp_req while rsp_busy=1 is ignored and needs no error pulse. rsp_* inputs may change after acceptance.
//  - rsp_err and rsp_done are never high in the same cycle.
// CONFIGURATION
//  RSP_CHKSUM_EN defined:
//    - CHK state present.
//    - Checksum = 8-bit XOR of header, length and all payload bytes, appended as the final byte.
//  RSP_CHKSUM_EN undefined:
//    - CHK state and checksum register removed.
//    - The frame ends after the last payload byte, or after the length byte when len=0.
// TESTING
//  - Reset mid-frame: assert rst_n=0 during PLD -> all outputs 0 next edge; a new request afterwards yields a complete, correct frame.
//  - page=1, status=0, len=2, payload 0xAA,0x55, tx_full=0 -> tx bytes 0x10,0x02,0xAA,0x55,0xED, then one rsp_done pulse.
//  - page=7, status=3, len=0 -> tx bytes 0x73,0x00,0x73, then rsp_done. With RSP_CHKSUM_EN undefined -> 0x73,0x00 only.
//  - page=2 or len=MAX_LEN+1 -> single rsp_err pulse, no tx_wr, rsp_busy stays 0.
//  - tx_full=1 for 5 cycles during payload byte 2 of 4 -> pld_ready low, no tx_wr while full, byte order and checksum unchanged.
//  - pld_valid low for TIMEOUT_CYC cycles after 1 of 3 bytes -> rsp_err pulse, only 3 bytes written (hdr, len, byte0), rsp_busy=0.

Source files
------------

// File: rtl/rsp_encode.sv
// rsp_encode: frames {page,status}, length and payload bytes into the TX FIFO.
// Define RSP_CHKSUM_EN to append an XOR checksum byte to every completed frame.
module rsp_encode #(
    parameter int MAX_LEN     = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rsp_req,
    input  logic [3:0] rsp_page,
    input  logic [3:0] rsp_status,
    input  logic [7:0] rsp_len,
    output logic       rsp_busy,
    input  logic [7:0] pld_data,
    input  logic       pld_valid,
    output logic       pld_ready,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       rsp_done,
    output logic       rsp_err
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] LEN  = 3'd2;
    localparam logic [2:0] PLD  = 3'd3;
    localparam logic [2:0] DONE = 3'd5;
`ifdef RSP_CHKSUM_EN
    localparam logic [2:0] CHK  = 3'd4;
    localparam logic [2:0] TAIL = CHK;
`else
    localparam logic [2:0] TAIL = DONE;
`endif
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    state;
    logic [7:0]    hdr, len, cnt;
    logic [TW-1:0] tcnt;
    logic          page_ok, xfer;
`ifdef RSP_CHKSUM_EN
    logic [7:0]    chk;
`endif

    assign page_ok   = rsp_page inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd7};
    assign pld_ready = (state == PLD) && !tx_full;
    assign xfer      = pld_ready && pld_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hdr      <= '0;
            len      <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            rsp_busy <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= '0;
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
`ifdef RSP_CHKSUM_EN
            chk      <= '0;
`endif
        end else begin
            tx_wr    <= 1'b0;
            rsp_done <= 1'b0;
            rsp_err  <= 1'b0;
            case (state)
                IDLE: if (rsp_req) begin
                    if (page_ok && rsp_len <= MAX_L) begin
                        hdr      <= {rsp_page, rsp_status};
                        len      <= rsp_len;
                        cnt      <= rsp_len;
                        rsp_busy <= 1'b1;
                        state    <= HDR;
                    end else begin
                        rsp_err  <= 1'b1;
                    end
                end
                HDR: if (!tx_full) begin
                    tx_wr   <= 1'b1;
                    tx_data <= hdr;
`ifdef RSP_CHKSUM_EN
                    chk     <= hdr;
`endif
                    state   <= LEN;
                end
                LEN: if (!tx_full) begin
                    tx_wr   <= 1'b1;
                    tx_data <= len;
`ifdef RSP_CHKSUM_EN
                    chk     <= chk ^ len;
`endif
                    tcnt    <= '0;
                    state   <= (len == 8'd0) ? TAIL : PLD;
                end
                PLD: if (xfer) begin
                    tx_wr   <= 1'b1;
                    tx_data <= pld_data;
`ifdef RSP_CHKSUM_EN
                    chk     <= chk ^ pld_data;
`endif
                    cnt     <= cnt - 8'd1;
                    tcnt    <= '0;
                    state   <= (cnt == 8'd1) ? TAIL : PLD;
                end else if (!pld_valid) begin
                    // a silent source abandons the frame without a checksum
                    if (tcnt == TO_LAST) begin
                        rsp_err  <= 1'b1;
                        rsp_busy <= 1'b0;
                        tcnt     <= '0;
                        state    <= IDLE;
                    end else begin
                        tcnt     <= tcnt + TW'(1);
                    end
                end
`ifdef RSP_CHKSUM_EN
                CHK: if (!tx_full) begin
                    tx_wr   <= 1'b1;
                    tx_data <= chk;
                    state   <= DONE;
                end
`endif
                DONE: begin
                    rsp_done <= 1'b1;
                    rsp_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
